sram_like_arb: RTL

Two-into-one arbiter for the CPU's sram-like bus. The instruction-fetch and data-access sram-like converters each present a master-side request; this block grants exactly one at a time onto the single sram-like port feeding the AXI bridge. It routes addr_ok, data_ok and rdata back to the owning requester. It keeps one transaction outstanding, holds the grant stable from request through data return, and never splits or reorders a transfer.

---
 rtl/sram_like_pkg.sv | 24 ++
 rtl/sram_like_arb_pick.sv | 33 +++
 rtl/sram_like_arb.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/sram_like_pkg.sv
// Shared encodings for the sram-like bus arbiter: FSM states, owner codes,
// transfer size codes and the request-field bundle carried on the port.
package sram_like_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_REQ       = 2'd1;
  localparam logic [1:0] ST_WAIT_DATA = 2'd2;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Request fields that travel with m_req.
  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sl_req_t;

endpackage

// File: rtl/sram_like_arb_pick.sv
// Combinational winner selection for the sram-like arbiter.
// ARB_RR_EN defined: a tie goes to the side that did not win last time.
// ARB_RR_EN undefined: fixed priority, data wins a tie.
// A lone requester always wins.
module sram_like_arb_pick
  import sram_like_pkg::*;
(
  input  logic inst_req,
  input  logic data_req,
  input  logic last_grant,
  output logic winner
);

`ifdef ARB_RR_EN
  // Round-robin on a tie, otherwise whoever is asking.
  always_comb begin
    winner = OWN_INST;
    if (inst_req && data_req) winner = ~last_grant;
    else if (data_req)        winner = OWN_DATA;
  end
`else
  // Fixed priority has no history; last_grant is deliberately ignored.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  // Data side wins any tie.
  always_comb begin
    winner = OWN_INST;
    if (data_req) winner = OWN_DATA;
  end
`endif

endmodule

// File: rtl/sram_like_arb.sv
// Two-into-one arbiter for the sram-like bus (inst fetch + data access).
// One transaction outstanding; the grant is locked from request through
// data return. Optional macro ARB_RR_EN selects round-robin tie breaking
// instead of fixed data-first priority.
module sram_like_arb
  import sram_like_pkg::*;
(
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata,

  output logic        busy
);

  logic [1:0] state_q;
  logic       owner_q;
  logic       last_grant;
  logic       winner;
  logic       sel;
  logic       sel_req;
  logic       idle_grant;
  logic       req_grant;
  logic       grant_act;
  logic       accept;
  logic       wait_done;
  sl_req_t    inst_f, data_f, sel_f, hold_q, m_f;

  assign inst_f = '{wr: inst_wr, size: inst_size, addr: inst_addr, wdata: inst_wdata};
  assign data_f = '{wr: data_wr, size: data_size, addr: data_addr, wdata: data_wdata};

  sram_like_arb_pick u_pick (
    .inst_req   (inst_req),
    .data_req   (data_req),
    .last_grant (last_grant),
    .winner     (winner)
  );

  // In IDLE the fresh winner is served; afterwards the grant is locked.
  assign sel     = (state_q == ST_IDLE) ? winner : owner_q;
  assign sel_req = sel ? data_req : inst_req;
  assign sel_f   = sel ? data_f : inst_f;

  // rst gates the combinational IDLE grant so nothing leaks out while held in reset.
  assign idle_grant = rst && (state_q == ST_IDLE) && (inst_req || data_req);
  assign req_grant  = (state_q == ST_REQ) && sel_req;
  assign grant_act  = idle_grant || req_grant;
  assign accept     = grant_act && m_addr_ok;
  // data_ok only counts while a transfer is actually outstanding; strays drop here.
  assign wait_done  = (state_q == ST_WAIT_DATA) && m_data_ok;

  // Shared-port field mux: winner/owner while requesting, latched copy while waiting.
  always_comb begin
    m_f = '0;
    case (state_q)
      ST_IDLE:      if (idle_grant) m_f = sel_f;
      ST_REQ:       m_f = sel_f;
      ST_WAIT_DATA: m_f = hold_q;
      default:      m_f = '0;
    endcase
  end

  assign m_req   = grant_act;
  assign m_wr    = m_f.wr;
  assign m_size  = m_f.size;
  assign m_addr  = m_f.addr;
  assign m_wdata = m_f.wdata;

  assign inst_addr_ok = accept && (sel == OWN_INST);
  assign data_addr_ok = accept && (sel == OWN_DATA);
  assign inst_data_ok = wait_done && (owner_q == OWN_INST);
  assign data_data_ok = wait_done && (owner_q == OWN_DATA);
  assign inst_rdata   = m_rdata;
  assign data_rdata   = m_rdata;

  assign busy = (state_q != ST_IDLE) || idle_grant;

  // Grant FSM and owner register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_INST;
    end else begin
      case (state_q)
        ST_IDLE: if (idle_grant) begin
          owner_q <= winner;
          state_q <= m_addr_ok ? ST_WAIT_DATA : ST_REQ;
        end
        ST_REQ: if (!sel_req) begin
          state_q <= ST_IDLE;
          owner_q <= OWN_INST;
        end else if (m_addr_ok) begin
          state_q <= ST_WAIT_DATA;
        end
        ST_WAIT_DATA: if (m_data_ok) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Capture the accepted request so the port fields stay put while waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        hold_q <= '0;
    else if (accept) hold_q <= sel_f;
  end

`ifdef ARB_RR_EN
  // Remember who was last accepted to break the next tie the other way.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        last_grant <= OWN_INST;
    else if (accept) last_grant <= sel;
  end
`else
  assign last_grant = OWN_INST;
`endif

endmodule
